// File: rtl/alu_v2.sv
// Accumulator/B-register ALU: arithmetic, logic and shift ops onto a tri-state bus,
// a registered {C,Z,N,V} flags register and a multi-cycle shift-and-add multiplier.
module alu_v2 #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [2:0]       OP,
    input  logic             Eu,
    input  logic             Fu,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       FLAGS,
    output logic [WIDTH-1:0] DBUS
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    state_t             state_q, state_d;
    logic               start_mul, finish;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_next, prod;
    logic [WIDTH-1:0]   mplier;
    logic               done_q;
    flags_t             flags_q, flags_d;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   result;
    logic               msb_a, msb_b, msb_r;

    assign BUSY  = (state_q == RUN);
    assign DONE  = done_q;
    assign FLAGS = flags_q;
    assign DBUS  = Eu ? result : {WIDTH{1'bz}};

    always_ff @(posedge CLK) begin
        if (CLR) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && (OP == OP_MUL) && MUL_EN) begin
                    state_d   = RUN;
                    start_mul = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            prod    <= '0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            done_q <= finish;
            if (start_mul) begin
                mcand  <= {{WIDTH{1'b0}}, ina};
                mplier <= inb;
                acc    <= '0;
                cnt    <= '0;
            end else if (state_q == RUN) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            // PROD is only touched on completion so the bus keeps the old product mid-run
            if (finish) prod <= acc_next;
            if (Fu && !BUSY) flags_q <= flags_d;
        end
    end

    assign sum   = {1'b0, ina} + {1'b0, inb};
    assign diff  = {1'b0, ina} - {1'b0, inb};
    assign msb_a = ina[WIDTH-1];
    assign msb_b = inb[WIDTH-1];
    assign msb_r = result[WIDTH-1];

    always_comb begin
        result    = '0;
        flags_d   = '0;
        case (OP)
            OP_ADD: begin
                result    = sum[WIDTH-1:0];
                flags_d.c = sum[WIDTH];
                flags_d.v = (msb_a == msb_b) && (msb_r != msb_a);
            end
            OP_SUB: begin
                result    = diff[WIDTH-1:0];
                flags_d.c = diff[WIDTH];
                flags_d.v = (msb_a != msb_b) && (msb_r != msb_a);
            end
            OP_AND: result = ina & inb;
            OP_OR:  result = ina | inb;
            OP_XOR: result = ina ^ inb;
            OP_SHL: begin
                result    = {ina[WIDTH-2:0], 1'b0};
                flags_d.c = ina[WIDTH-1];
            end
            OP_SHR: begin
                result    = {1'b0, ina[WIDTH-1:1]};
                flags_d.c = ina[0];
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    result    = prod[WIDTH-1:0];
                    flags_d.c = |prod[2*WIDTH-1:WIDTH];
                end
            end
            default: result = '0;
        endcase
        flags_d.z = (result == '0);
        flags_d.n = msb_r;
    end

endmodule
